// File: rtl/gray_sync_decoder.sv
// gray_sync_decoder
// Brings a free-running Gray up-count from a foreign clock domain into the
// local domain. It synchronises the count, converts it to binary and checks
// that every observed change is a single +1 step. Accepted steps produce
// inc_pulse, and wrap_pulse when the count rolls over to zero. Any illegal
// change latches a fault until clear_err is seen.
//
// Optional feature macro: GRAY_ERR_CNT_EN
//   defined   -> 8-bit saturating count of fault entries on err_cnt
//                (cleared only by reset)
//   undefined -> err_cnt is tied to zero
//
// SYNC_STAGES is expected to be in the range 2..4.

module gray_sync_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clear_err,
  output logic [WIDTH-1:0] bin_out,
  output logic             bin_valid,
  output logic             inc_pulse,
  output logic             wrap_pulse,
  output logic             err,
  output logic [7:0]       err_cnt
);

  // Width of the popcount of the Gray difference (0..WIDTH)
  localparam int PW = $clog2(WIDTH + 1);
  // Width of the INIT fill counter (0..SYNC_STAGES)
  localparam int CW = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  // Gray-to-binary: the MSB passes through and each lower bit is the XOR
  // of the binary bit above it with its own Gray bit.
  function automatic logic [WIDTH-1:0] grayToBin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_gPrev;
  logic [WIDTH-1:0] r_bin;
  logic             r_valid;
  logic             r_inc;
  logic             r_wrap;
  logic             r_err;
  logic [CW-1:0]    r_fill;
  state_t           r_state;

  logic [WIDTH-1:0] w_gS;
  logic [WIDTH-1:0] w_binS;
  logic [WIDTH-1:0] w_binPrev;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_delta;
  logic [PW-1:0]    w_popcnt;
  logic             w_noChange;
  logic             w_legalInc;
  logic             w_illegal;

  state_t           w_stateNext;
  logic [CW-1:0]    w_fillNext;
  logic [WIDTH-1:0] w_gPrevNext;
  logic [WIDTH-1:0] w_binNext;
  logic             w_validNext;
  logic             w_incNext;
  logic             w_wrapNext;
  logic             w_errNext;

  // Synchroniser chain; only the final stage is allowed downstream.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_gS      = r_sync[SYNC_STAGES-1];
  assign w_binS    = grayToBin(w_gS);
  assign w_binPrev = grayToBin(r_gPrev);
  assign w_diff    = w_gS ^ r_gPrev;
  assign w_delta   = w_binS - w_binPrev;

  // Count how many Gray bits changed since the last accepted value.
  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_popcnt = w_popcnt + {{(PW-1){1'b0}}, w_diff[i]};
    end
  end

  // A legal step flips exactly one bit and advances the binary value by one;
  // a single-bit flip that goes backwards, or any multi-bit jump, is illegal.
  assign w_noChange = (w_popcnt == PW'(0));
  assign w_legalInc = (w_popcnt == PW'(1)) && (w_delta == WIDTH'(1));
  assign w_illegal  = !w_noChange && !w_legalInc;

  // FSM state and datapath registers; all outputs come straight from here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_INIT;
      r_fill  <= '0;
      r_gPrev <= '0;
      r_bin   <= '0;
      r_valid <= 1'b0;
      r_inc   <= 1'b0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_fill  <= w_fillNext;
      r_gPrev <= w_gPrevNext;
      r_bin   <= w_binNext;
      r_valid <= w_validNext;
      r_inc   <= w_incNext;
      r_wrap  <= w_wrapNext;
      r_err   <= w_errNext;
    end
  end

  // Next-state and next-output decode. INIT lets the synchroniser fill
  // before taking a baseline; TRACK accepts +1 steps; FAULT waits for
  // clear_err and then re-baselines through INIT.
  always_comb begin
    w_stateNext = r_state;
    w_fillNext  = r_fill;
    w_gPrevNext = r_gPrev;
    w_binNext   = r_bin;
    w_validNext = 1'b0;
    w_incNext   = 1'b0;
    w_wrapNext  = 1'b0;
    w_errNext   = 1'b0;
    unique case (r_state)
      S_INIT: begin
        if (r_fill == CW'(SYNC_STAGES)) begin
          w_gPrevNext = w_gS;
          w_binNext   = w_binS;
          w_validNext = 1'b1;
          w_stateNext = S_TRACK;
        end else begin
          w_fillNext = r_fill + CW'(1);
        end
      end
      S_TRACK: begin
        w_validNext = 1'b1;
        if (w_legalInc) begin
          w_gPrevNext = w_gS;
          w_binNext   = w_binS;
          w_incNext   = 1'b1;
          w_wrapNext  = (w_binS == '0);
        end else if (w_illegal) begin
          w_validNext = 1'b0;
          w_errNext   = 1'b1;
          w_stateNext = S_FAULT;
        end
      end
      S_FAULT: begin
        w_errNext = 1'b1;
        if (clear_err) begin
          w_errNext   = 1'b0;
          w_fillNext  = '0;
          w_stateNext = S_INIT;
        end
      end
      default: begin
        w_fillNext  = '0;
        w_stateNext = S_INIT;
      end
    endcase
  end

`ifdef GRAY_ERR_CNT_EN
  logic       w_faultEntry;
  logic [7:0] r_errCnt;

  assign w_faultEntry = (r_state == S_TRACK) && w_illegal;

  // Saturating count of fault entries; clear_err deliberately leaves it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_errCnt <= 8'd0;
    end else if (w_faultEntry && (r_errCnt != 8'hFF)) begin
      r_errCnt <= r_errCnt + 8'd1;
    end
  end

  assign err_cnt = r_errCnt;
`else
  assign err_cnt = 8'd0;
`endif

  assign bin_out    = r_bin;
  assign bin_valid  = r_valid;
  assign inc_pulse  = r_inc;
  assign wrap_pulse = r_wrap;
  assign err        = r_err;

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Testbench for gray_sync_decoder (WIDTH=4, SYNC_STAGES=2).
// A behavioural model tracks the expected outputs from the decoder's rules
// (delayed sampling, +1 legality in binary, fault latch, saturating count).

module tb_gray_sync_decoder;

  localparam int WIDTH = 4;
  localparam int SYNC  = 2;

`ifdef GRAY_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] gray_in = '0;
  logic             clear_err = 1'b0;
  logic [WIDTH-1:0] bin_out;
  logic             bin_valid;
  logic             inc_pulse;
  logic             wrap_pulse;
  logic             err;
  logic [7:0]       err_cnt;

  int tests = 0;
  int failures = 0;

  gray_sync_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_in    (gray_in),
    .clear_err  (clear_err),
    .bin_out    (bin_out),
    .bin_valid  (bin_valid),
    .inc_pulse  (inc_pulse),
    .wrap_pulse (wrap_pulse),
    .err        (err),
    .err_cnt    (err_cnt)
  );

  // Free-running local clock
  always #5 clk = ~clk;

  function automatic logic [3:0] toBin(input logic [3:0] g);
    logic [3:0] b;
    b = g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3);
    return b;
  endfunction

  function automatic logic [3:0] toGray(input int n);
    logic [3:0] v;
    v = n[3:0];
    return v ^ (v >> 1);
  endfunction

  // ---------------- reference model ----------------
  logic [3:0] seen[$];
  logic [3:0] mGs = '0;
  logic [3:0] mPrev = '0;
  logic [3:0] mBin = '0;
  logic [3:0] mNext = '0;
  logic       mValid = 1'b0;
  logic       mInc = 1'b0;
  logic       mWrap = 1'b0;
  logic       mErr = 1'b0;
  int         mCnt = 0;
  int         fill = 0;
  bit         based = 1'b0;
  bit         faulted = 1'b0;

  // Model update per local edge, cleared asynchronously by reset
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      seen.delete();
      fill = 0; based = 1'b0; faulted = 1'b0;
      mPrev = '0; mBin = '0; mValid = 1'b0; mInc = 1'b0; mWrap = 1'b0;
      mErr = 1'b0; mCnt = 0;
    end else begin
      mGs = (seen.size() >= SYNC) ? seen[seen.size() - SYNC] : 4'd0;
      mInc = 1'b0;
      mWrap = 1'b0;
      if (faulted) begin
        if (clear_err) begin
          faulted = 1'b0; fill = 0; mErr = 1'b0;
        end
      end else if (!based) begin
        if (fill == SYNC) begin
          based = 1'b1; mPrev = mGs; mBin = toBin(mGs); mValid = 1'b1;
        end else begin
          fill++;
        end
      end else if (mGs != mPrev) begin
        mNext = toBin(mPrev) + 4'd1;
        if (toBin(mGs) == mNext) begin
          mPrev = mGs; mBin = mNext; mInc = 1'b1; mWrap = (mNext == 4'd0);
        end else begin
          faulted = 1'b1; based = 1'b0; mValid = 1'b0; mErr = 1'b1;
          if (mCnt < 255) mCnt++;
        end
      end
      seen.push_back(gray_in);
      if (seen.size() > SYNC) void'(seen.pop_front());
    end
  end

  logic [15:0] obsVec;
  logic [15:0] expVec;
  assign obsVec = {bin_out, bin_valid, inc_pulse, wrap_pulse, err, err_cnt};
  always_comb expVec = {mBin, mValid, mInc, mWrap, mErr, (CNT_EN ? mCnt[7:0] : 8'd0)};

  // Stimulus only: reset with a held value and wait until baselined
  task automatic rebase(input logic [3:0] g);
    @(negedge clk);
    reset = 1'b1; gray_in = g; clear_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; gray_in = 4'b0110; clear_err = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (obsVec !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_hold: got %h want %h", obsVec, 16'h0000);
    end
    reset = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      tests++;
      if (obsVec !== expVec) begin
        failures++;
        $display("[TB] FAIL baseline_model e%0d: got %h want %h", e, obsVec, expVec);
      end
      tests++;
      if (inc_pulse !== 1'b0) begin
        failures++;
        $display("[TB] FAIL baseline_noinc e%0d: got %b want 0", e, inc_pulse);
      end
      if (e < 3) begin
        tests++;
        if (bin_valid !== 1'b0) begin
          failures++;
          $display("[TB] FAIL baseline_early e%0d: got %b want 0", e, bin_valid);
        end
      end else if (e == 3) begin
        tests++;
        if ({bin_valid, bin_out} !== {1'b1, 4'd4}) begin
          failures++;
          $display("[TB] FAIL baseline_edge3: got %b/%0d want 1/4", bin_valid, bin_out);
        end
      end
    end
  endtask

  task automatic test_legal_stepping();
    int incSeen;
    logic [3:0] want;
    incSeen = 0;
    rebase(toGray(0));
    for (int v = 1; v <= 15; v++) begin
      gray_in = toGray(v);
      want = v[3:0];
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        if (inc_pulse === 1'b1) incSeen++;
        tests++;
        if (obsVec !== expVec) begin
          failures++;
          $display("[TB] FAIL step_model v%0d c%0d: got %h want %h", v, c, obsVec, expVec);
        end
        if (c == 3) begin
          tests++;
          if ({inc_pulse, bin_out, err} !== {1'b1, want, 1'b0}) begin
            failures++;
            $display("[TB] FAIL step_latency v%0d: got inc=%b bin=%0d err=%b want 1/%0d/0",
                     v, inc_pulse, bin_out, err, want);
          end
        end
      end
    end
    tests++;
    if (incSeen != 15) begin
      failures++;
      $display("[TB] FAIL step_count: got %0d want 15", incSeen);
    end
  endtask

  task automatic test_wrap();
    gray_in = 4'b0000;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      tests++;
      if (obsVec !== expVec) begin
        failures++;
        $display("[TB] FAIL wrap_model c%0d: got %h want %h", c, obsVec, expVec);
      end
      if (c == 3) begin
        tests++;
        if ({inc_pulse, wrap_pulse, bin_out, err} !== {2'b11, 4'd0, 1'b0}) begin
          failures++;
          $display("[TB] FAIL wrap_pulse: got inc=%b wrap=%b bin=%0d err=%b want 1/1/0/0",
                   inc_pulse, wrap_pulse, bin_out, err);
        end
      end
    end
  endtask

  task automatic test_illegal_recovery();
    logic [7:0] cntWant;
    rebase(4'b0001);
    // Multi-bit jump 1 -> 5
    gray_in = 4'b0111;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      tests++;
      if (obsVec !== expVec) begin
        failures++;
        $display("[TB] FAIL jump_model c%0d: got %h want %h", c, obsVec, expVec);
      end
      if (c == 3) begin
        cntWant = CNT_EN ? 8'd1 : 8'd0;
        tests++;
        if ({err, bin_valid, bin_out, err_cnt} !== {1'b1, 1'b0, 4'd1, cntWant}) begin
          failures++;
          $display("[TB] FAIL jump_fault: got err=%b valid=%b bin=%0d cnt=%0d want 1/0/1/%0d",
                   err, bin_valid, bin_out, err_cnt, cntWant);
        end
      end
    end
    // Recover at bin 5, then step backwards to 4, then recover again at 4
    for (int phase = 0; phase < 2; phase++) begin
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      tests++;
      if (err !== 1'b0) begin
        failures++;
        $display("[TB] FAIL clear_drop p%0d: got %b want 0", phase, err);
      end
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        tests++;
        if (bin_valid !== (c == 3)) begin
          failures++;
          $display("[TB] FAIL clear_valid p%0d c%0d: got %b want %b", phase, c, bin_valid, (c == 3));
        end
      end
      tests++;
      if (bin_out !== ((phase == 0) ? 4'd5 : 4'd4)) begin
        failures++;
        $display("[TB] FAIL clear_value p%0d: got %0d want %0d", phase, bin_out, (phase == 0) ? 5 : 4);
      end
      if (phase == 0) begin
        gray_in = 4'b0110;
        for (int c = 1; c <= 4; c++) begin
          @(negedge clk);
          tests++;
          if (obsVec !== expVec) begin
            failures++;
            $display("[TB] FAIL back_model c%0d: got %h want %h", c, obsVec, expVec);
          end
          if (c == 3) begin
            cntWant = CNT_EN ? 8'd2 : 8'd0;
            tests++;
            if ({err, bin_valid, bin_out, err_cnt} !== {1'b1, 1'b0, 4'd5, cntWant}) begin
              failures++;
              $display("[TB] FAIL back_fault: got err=%b valid=%b bin=%0d cnt=%0d want 1/0/5/%0d",
                       err, bin_valid, bin_out, err_cnt, cntWant);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    rebase(toGray(9));
    tests++;
    if ({bin_valid, bin_out} !== {1'b1, 4'd9}) begin
      failures++;
      $display("[TB] FAIL midop_pre: got %b/%0d want 1/9", bin_valid, bin_out);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (obsVec !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL midop_async: got %h want %h", obsVec, 16'h0000);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      tests++;
      if (obsVec !== expVec) begin
        failures++;
        $display("[TB] FAIL midop_model c%0d: got %h want %h", c, obsVec, expVec);
      end
      if (c == 3) begin
        tests++;
        if ({bin_valid, bin_out} !== {1'b1, 4'd9}) begin
          failures++;
          $display("[TB] FAIL midop_rebase: got %b/%0d want 1/9", bin_valid, bin_out);
        end
      end
    end
  endtask

  task automatic test_random();
    int cur;
    int kind;
    int hold;
    cur = $urandom_range(0, 15);
    rebase(toGray(cur));
    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 9);
      hold = $urandom_range(1, 5);
      if (kind <= 6) begin
        cur = (cur + 1) % 16;
        gray_in = toGray(cur);
      end else if (kind == 7) begin
        cur = $urandom_range(0, 15);
        gray_in = toGray(cur);
      end else if (kind == 8) begin
        clear_err = 1'b1;
      end
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        clear_err = 1'b0;
        tests++;
        if (obsVec !== expVec) begin
          failures++;
          $display("[TB] FAIL random_model it%0d c%0d: got %h want %h", it, c, obsVec, expVec);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int cur;
    cur = 0;
    rebase(toGray(0));
    for (int k = 0; k < 300; k++) begin
      cur = (cur + 2) % 16;
      gray_in = toGray(cur);
      repeat (4) @(negedge clk);
      tests++;
      if (obsVec !== expVec) begin
        failures++;
        $display("[TB] FAIL sat_fault k%0d: got %h want %h", k, obsVec, expVec);
      end
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (obsVec !== expVec) begin
        failures++;
        $display("[TB] FAIL sat_rebase k%0d: got %h want %h", k, obsVec, expVec);
      end
    end
    tests++;
    if (err_cnt !== (CNT_EN ? 8'd255 : 8'd0)) begin
      failures++;
      $display("[TB] FAIL sat_final: got %0d want %0d", err_cnt, CNT_EN ? 255 : 0);
    end
  endtask

  initial begin
    test_reset();
    test_legal_stepping();
    test_wrap();
    test_illegal_recovery();
    test_reset_midop();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
